// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. queued long-latency results.
// Optional starvation guard for queued results is enabled by defining WB_ARB_AGING_EN.
module wb_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PIPE_i_valid,
  input  logic [4:0]               PIPE_i_rd,
  input  logic [WIDTH-1:0]         PIPE_i_valW,
  output logic                     PIPE_o_stall,
  input  logic                     LONG_i_valid,
  input  logic [4:0]               LONG_i_rd,
  input  logic [WIDTH-1:0]         LONG_i_val,
  output logic                     LONG_o_ready,
  output logic                     REG_o_wen,
  output logic [4:0]               REG_o_waddr,
  output logic [WIDTH-1:0]         REG_o_wdata,
  output logic [$clog2(DEPTH):0]   ARB_o_fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("wb_port_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  logic [4:0]       rd_mem  [DEPTH];
  logic [WIDTH-1:0] val_mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic             full, empty, force_drain;
  logic             pipe_grant, pop, push;
  logic [4:0]       grant_rd;
  logic [WIDTH-1:0] grant_val;

  assign full           = (count == CW'(DEPTH));
  assign empty          = (count == '0);
  assign LONG_o_ready   = !full;
  // Stall depends only on registered state, so there is no combinational path from the requesters.
  assign PIPE_o_stall   = full || force_drain;
  assign ARB_o_fifo_cnt = count;

  always_comb begin
    pipe_grant = PIPE_i_valid && !PIPE_o_stall;
    pop        = !pipe_grant && !empty;
    push       = LONG_i_valid && !full;
    grant_rd   = pipe_grant ? PIPE_i_rd   : rd_mem[rd_ptr];
    grant_val  = pipe_grant ? PIPE_i_valW : val_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]  <= LONG_i_rd;
      val_mem[wr_ptr] <= LONG_i_val;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // x0 is never written, but a grant to it still consumes the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      REG_o_wen   <= 1'b0;
      REG_o_waddr <= '0;
      REG_o_wdata <= '0;
    end else begin
      REG_o_wen <= (pipe_grant || pop) && (grant_rd != 5'd0);
      if (pipe_grant || pop) begin
        REG_o_waddr <= grant_rd;
        REG_o_wdata <= grant_val;
      end
    end
  end

`ifdef WB_ARB_AGING_EN
  localparam int AW = $clog2(STARVE_LIMIT) + 1;
  logic [AW-1:0] age;

  assign force_drain = (age == AW'(STARVE_LIMIT));

  // Counts pipeline grants that bypass a waiting queued result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (pop || empty) begin
      age <= '0;
    end else if (pipe_grant) begin
      age <= age + 1'b1;
    end
  end
`else
  assign force_drain = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// every register-file write, and an independent monitor checks them as they appear.
module tb_wb_port_arbiter;

  localparam int WIDTH        = 32;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   pipe_valid;
  logic [4:0]             pipe_rd;
  logic [WIDTH-1:0]       pipe_val;
  logic                   pipe_stall;
  logic                   long_valid;
  logic [4:0]             long_rd;
  logic [WIDTH-1:0]       long_val;
  logic                   long_ready;
  logic                   reg_wen;
  logic [4:0]             reg_waddr;
  logic [WIDTH-1:0]       reg_wdata;
  logic [$clog2(DEPTH):0] fifo_cnt;

  wb_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PIPE_i_valid   (pipe_valid),
    .PIPE_i_rd      (pipe_rd),
    .PIPE_i_valW    (pipe_val),
    .PIPE_o_stall   (pipe_stall),
    .LONG_i_valid   (long_valid),
    .LONG_i_rd      (long_rd),
    .LONG_i_val     (long_val),
    .LONG_o_ready   (long_ready),
    .REG_o_wen      (reg_wen),
    .REG_o_waddr    (reg_waddr),
    .REG_o_wdata    (reg_wdata),
    .ARB_o_fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] rd; logic [WIDTH-1:0] val; } entry_t;
  typedef struct { logic [4:0] rd; logic [WIDTH-1:0] val; int due; } wr_t;

  entry_t model_q[$];
  wr_t    exp_q[$];
  int     age = 0;
  int     n_checks = 0;
  int     n_fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit model_stall();
    bit f = 1'b0;
`ifdef WB_ARB_AGING_EN
    f = (age == STARVE_LIMIT);
`endif
    return (model_q.size() == DEPTH) || f;
  endfunction

  task automatic checkOutput();
    check("stall", pipe_stall, model_stall());
    check("ready", long_ready, model_q.size() != DEPTH);
    check("fifo_cnt", fifo_cnt, model_q.size());
  endtask

  task automatic check_reset();
    check("reset wen", reg_wen, 0);
    check("reset ready", long_ready, 1);
    check("reset stall", pipe_stall, 0);
    check("reset fifo_cnt", fifo_cnt, 0);
  endtask

  // Called at a negedge: checks state, predicts this cycle's grant, drives inputs, waits one cycle.
  task automatic applyStimulus(input bit pv, input logic [4:0] prd, input logic [WIDTH-1:0] pval,
                               input bit lv, input logic [4:0] lrd, input logic [WIDTH-1:0] lval);
    bit     stall_m, pipe_g, pop_m, push_m;
    int     size_before;
    entry_t e;
    checkOutput();
    size_before = model_q.size();
    stall_m = model_stall();
    pipe_g  = pv && !stall_m;
    pop_m   = !pipe_g && size_before > 0;
    push_m  = lv && size_before != DEPTH;
    if (pipe_g && prd != 0) exp_q.push_back('{rd: prd, val: pval, due: cyc + 1});
    if (pop_m) begin
      e = model_q.pop_front();
      if (e.rd != 0) exp_q.push_back('{rd: e.rd, val: e.val, due: cyc + 1});
    end
    if (push_m) model_q.push_back('{rd: lrd, val: lval});
`ifdef WB_ARB_AGING_EN
    if (pop_m || size_before == 0) age = 0;
    else if (pipe_g) age++;
`endif
    pipe_valid = pv;  pipe_rd = prd;  pipe_val = pval;
    long_valid = lv;  long_rd = lrd;  long_val = lval;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  // Monitor: every observed write must match the oldest predicted write, on its predicted cycle.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n === 1'b1) begin
      if (reg_wen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected write: got waddr %0d wdata 0x%0h, required no write (cycle %0d)",
                   reg_waddr, reg_wdata, cyc);
        end else begin
          w = exp_q.pop_front();
          check("write cycle", cyc, w.due);
          check("waddr", reg_waddr, w.rd);
          check("wdata", reg_wdata, w.val);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        w = exp_q.pop_front();
        n_checks++;
        n_fails++;
        $display("[TB] FAIL missing write: got wen 0, required write rd %0d val 0x%0h (cycle %0d)",
                 w.rd, w.val, cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    pipe_valid = 0; pipe_rd = 0; pipe_val = 0;
    long_valid = 0; long_rd = 0; long_val = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    applyStimulus(1, 5'd5, 32'h1234, 0, 0, 0);
    idle(2);

    applyStimulus(1, 5'd1, 32'h100, 1, 5'd7, 32'hA);
    applyStimulus(1, 5'd2, 32'h200, 1, 5'd8, 32'hB);
    for (int i = 0; i < 4; i++) applyStimulus(1, 5'(9 + i), 32'(i), 0, 0, 0);
    idle(3);

    applyStimulus(1, 5'd0, 32'hFFFF, 0, 0, 0);
    idle(1);

    applyStimulus(1, 5'd4, 32'h44, 1, 5'd2, 32'h22);
    applyStimulus(0, 0, 0, 1, 5'd3, 32'h33);
    idle(3);

    applyStimulus(1, 5'd10, 32'hC0DE, 1, 5'd20, 32'h55);
    for (int i = 0; i < 12; i++) applyStimulus(1, 5'(11 + i), 32'(i * 3), 0, 0, 0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      int lp = (i < 300) ? 50 : 85;
      applyStimulus($urandom_range(0, 99) < 70, rand_rd(), $urandom(),
                    $urandom_range(0, 99) < lp, rand_rd(), $urandom());
    end

    applyStimulus(1, 5'd6, 32'h66, 1, 5'd9, 32'h99);
    applyStimulus(1, 5'd6, 32'h67, 1, 5'd9, 32'h98);
    #2 rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    age = 0;
    pipe_valid = 0; long_valid = 0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 1), rand_rd(), $urandom(),
                    $urandom_range(0, 1), rand_rd(), $urandom());

    idle(8);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between the in-order pipeline writeback result (already muxed, valW) and late results from the long-latency unit (multiply/divide, CSR side effects).
- Long results are queued in a small FIFO and drained on pipeline bubbles, or by stalling the pipeline when the FIFO fills.
- Drives registered write enable, address and data into the register file.

Parameters:
- WIDTH, 32, data width of the register-file write port.
- DEPTH, 2, long-result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive pipeline grants allowed while the FIFO is non-empty (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- PIPE_i_valid  input  1  pipeline has a writeback this cycle.
- PIPE_i_rd  input  5  pipeline destination register.
- PIPE_i_valW  input  WIDTH  pipeline writeback value.
- PIPE_o_stall  output  1  pipeline must hold its writeback stage; pipeline result is not consumed.
- LONG_i_valid  input  1  long-unit result valid.
- LONG_i_rd  input  5  long-unit destination register.
- LONG_i_val  input  WIDTH  long-unit result.
- LONG_o_ready  output  1  FIFO can accept; transfer occurs when valid and ready.
- REG_o_wen  output  1  register-file write enable.
- REG_o_waddr  output  5  register-file write address.
- REG_o_wdata  output  WIDTH  register-file write data.
- ARB_o_fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers and count 0, REG_o_wen/waddr/wdata 0, PIPE_o_stall 0, LONG_o_ready 1, ARB_o_fifo_cnt 0, aging counter 0.
- LONG_o_ready = (count != DEPTH), combinational from registered count. Push of {rd, val} on LONG_i_valid && LONG_o_ready.
- PIPE_o_stall = (count == DEPTH) || force_drain, combinational from registered state only. There is no path from PIPE_i_* or LONG_i_*.
- Grant per cycle:
  - If PIPE_i_valid && !PIPE_o_stall, grant the pipeline.
  - Else if the FIFO is non-empty, grant the FIFO head and pop.
  - Else no grant.
- Latency: one cycle. A grant in cycle N sets REG_o_wen/waddr/wdata at edge N+1, held for exactly one cycle.
- With no grant, REG_o_wen = 0; REG_o_waddr and REG_o_wdata hold their previous values.
- rd == 0: the grant and pop still occur, but REG_o_wen = 0 (x0 never written).
- Simultaneous push and pop: count unchanged, pointers both advance. A push into a full FIFO is impossible, because ready is low.
- Full FIFO: the pipeline stalls, and one entry pops this cycle. Ready rises the following cycle.
- FIFO order is preserved (FIFO drain order equals LONG acceptance order). Cross-requester RAW/WAW ordering is the upstream scoreboard's responsibility.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset mid-operation discards all queued entries. No write issues after rst_n deasserts until a new grant.

Optional Feature:
- WB_ARB_AGING_EN defined:
  - An aging counter ($clog2(STARVE_LIMIT)+1 bits) increments each cycle the FIFO is non-empty and the pipeline is granted.
  - It clears on any FIFO pop or when the FIFO is empty.
  - When the counter equals STARVE_LIMIT, force_drain = 1 for one cycle: the pipeline stalls, the head pops, and the counter clears.
- Undefined: force_drain is constant 0 and the counter is absent. The FIFO drains only on pipeline bubbles or when full.

Test Plan:
- Reset with rst_n low for 3 cycles -> REG_o_wen=0, LONG_o_ready=1, PIPE_o_stall=0, ARB_o_fifo_cnt=0.
- PIPE valid rd=5 valW=0x1234, FIFO empty -> next edge: REG_o_wen=1, waddr=5, wdata=0x1234, no stall.
- LONG pushes rd=7 val=0xA, then rd=8 val=0xB, while the pipeline is continuously valid -> cnt=2, ready=0, stall=1. Next edges write rd=7 then rd=8 in order. Pipeline is unstalled once cnt<2.
- Pipeline valid rd=0 valW=0xFFFF -> REG_o_wen stays 0 at the next edge.
- Push rd=3 and pop in the same cycle with cnt=1 -> cnt remains 1; the write order is preserved.
- With WB_ARB_AGING_EN and STARVE_LIMIT=8: one FIFO entry and the pipeline valid every cycle -> after 8 pipeline grants, a one-cycle stall occurs and the FIFO entry is written. Without the macro, no stall occurs and the entry stays queued.
